// File: rtl/fusion_acc_array.sv
`default_nettype none
// fusion_acc_array: per-channel group accumulator with optional saturation, sticky overflow,
// saturating beat counter and a one-entry valid/ready result register.  Rev 1.0
module fusion_acc_array #(
  parameter int IN_W   = 20,
  parameter int ACC_W  = 28,
  parameter int CH     = 4,
  parameter int CNT_W  = 8,
  parameter int SAT_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*IN_W-1:0]  in_data,
  input  logic                in_signed,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*ACC_W-1:0] out_data,
  output logic [CH-1:0]       out_ovf,
  output logic [CNT_W-1:0]    out_count,
  output logic                busy
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q;
  logic [CH*ACC_W-1:0]  acc_q, acc_d;
  logic [CH-1:0]        ovf_q, ovf_now;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q;
  logic [CH*ACC_W-1:0]  out_data_q;
  logic [CH-1:0]        out_ovf_q;
  logic [CNT_W-1:0]     out_count_q;
  logic                 accept;

  assign in_ready  = !(out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;
  assign cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;
  assign busy      = (state_q == RUN);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [IN_W-1:0]  lane;
    logic [ACC_W-1:0] acc_c;
    logic [ACC_W:0]   ext;
    logic [ACC_W:0]   sum;

    assign lane  = in_data[c*IN_W +: IN_W];
    assign acc_c = acc_q[c*ACC_W +: ACC_W];
    assign ext   = {{(ACC_W+1-IN_W){in_signed & lane[IN_W-1]}}, lane};
    assign sum   = {acc_c[ACC_W-1], acc_c} + ext;
    // The (ACC_W+1)-bit sum cannot itself overflow, so a top-two-bit mismatch is exact.
    assign ovf_now[c] = sum[ACC_W] ^ sum[ACC_W-1];

    if (SAT_EN != 0) begin : g_sat
      assign acc_d[c*ACC_W +: ACC_W] = !ovf_now[c] ? sum[ACC_W-1:0]
                                     : (sum[ACC_W] ? ACC_MIN : ACC_MAX);
    end else begin : g_wrap
      assign acc_d[c*ACC_W +: ACC_W] = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= '0;
      out_count_q <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        if (in_last) begin
          // Close the group: publish totals and restart from zero in the same edge.
          state_q     <= IDLE;
          acc_q       <= '0;
          ovf_q       <= '0;
          cnt_q       <= '0;
          out_valid_q <= 1'b1;
          out_data_q  <= acc_d;
          out_ovf_q   <= ovf_q | ovf_now;
          out_count_q <= cnt_d;
        end else begin
          state_q <= RUN;
          acc_q   <= acc_d;
          ovf_q   <= ovf_q | ovf_now;
          cnt_q   <= cnt_d;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fusion_acc_array.sv
`default_nettype none
// tb_fusion_acc_array: randomized and directed stimulus against a behavioural model,
// scoreboard-checked for both saturating and wrapping builds.  Rev 1.0
module tb_fusion_acc_array;

  localparam int IN_W  = 20;
  localparam int ACC_W = 28;
  localparam int CH    = 4;
  localparam int CNT_W = 8;
  localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC_W-1));

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [CH*IN_W-1:0] in_data = '0;
  logic in_signed = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;

  logic in_ready, out_valid, busy;
  logic [CH*ACC_W-1:0] out_data;
  logic [CH-1:0] out_ovf;
  logic [CNT_W-1:0] out_count;
  logic in_ready_w, out_valid_w, busy_w;
  logic [CH*ACC_W-1:0] out_data_w;
  logic [CH-1:0] out_ovf_w;
  logic [CNT_W-1:0] out_count_w;

  fusion_acc_array #(.IN_W(IN_W), .ACC_W(ACC_W), .CH(CH), .CNT_W(CNT_W), .SAT_EN(1)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_signed(in_signed), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_count(out_count), .busy(busy));

  fusion_acc_array #(.IN_W(IN_W), .ACC_W(ACC_W), .CH(CH), .CNT_W(CNT_W), .SAT_EN(0)) dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .in_signed(in_signed), .in_last(in_last), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_data(out_data_w), .out_ovf(out_ovf_w), .out_count(out_count_w), .busy(busy_w));

  always #5 clk = ~clk;

  typedef struct {
    logic [CH*ACC_W-1:0] ds;
    logic [CH*ACC_W-1:0] dw;
    logic [CH-1:0]       os;
    logic [CH-1:0]       ow;
    logic [CNT_W-1:0]    cnt;
  } exp_t;

  exp_t   exp_q[$];
  longint m_sat[CH];
  longint m_wrap[CH];
  logic [CH-1:0] mo_s, mo_w;
  int     m_cnt;
  bit     tb_open = 1'b0;
  int     rdy_mode = 1;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic longint wrapv(input longint v);
    longint m;
    m = v & ((longint'(1) << ACC_W) - 1);
    if (m > MAXV) m = m - (longint'(1) << ACC_W);
    return m;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < CH; c++) begin
      m_sat[c] = 0;
      m_wrap[c] = 0;
    end
    mo_s = '0;
    mo_w = '0;
    m_cnt = 0;
  endfunction

  // Reference: true integer sums, clamped or reduced modulo 2^ACC_W.
  function automatic void model_beat(input logic [CH*IN_W-1:0] d, input bit s, input bit l);
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      logic [IN_W-1:0] lane;
      longint x, ss, sw;
      lane = d[c*IN_W +: IN_W];
      x = longint'(lane);
      if (s && lane[IN_W-1]) x = x - (longint'(1) << IN_W);
      ss = m_sat[c] + x;
      if (ss > MAXV) begin ss = MAXV; mo_s[c] = 1'b1; end
      else if (ss < MINV) begin ss = MINV; mo_s[c] = 1'b1; end
      m_sat[c] = ss;
      sw = m_wrap[c] + x;
      if (sw > MAXV || sw < MINV) mo_w[c] = 1'b1;
      m_wrap[c] = wrapv(sw);
    end
    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    if (l) begin
      for (int c = 0; c < CH; c++) begin
        e.ds[c*ACC_W +: ACC_W] = m_sat[c][ACC_W-1:0];
        e.dw[c*ACC_W +: ACC_W] = m_wrap[c][ACC_W-1:0];
      end
      e.os = mo_s;
      e.ow = mo_w;
      e.cnt = CNT_W'(m_cnt);
      exp_q.push_back(e);
      model_clear();
    end
  endfunction

  task automatic finish_now();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic drive_beat(input logic [CH*IN_W-1:0] d, input bit s, input bit l);
    int waitc = 0;
    in_valid = 1'b1; in_data = d; in_signed = s; in_last = l;
    @(negedge clk);
    while (!in_ready) begin
      waitc++;
      if (waitc > 1000) begin
        checks++; errors++;
        $display("FAIL beat_timeout: in_ready stuck at 0 required 1");
        finish_now();
      end
      @(negedge clk);
    end
    model_beat(d, s, l);
    @(posedge clk);
    tb_open = !l;
    #2;
    in_valid = 1'b0;
  endtask

  task automatic beat4(input int v0, input int v1, input int v2, input int v3,
                       input bit s, input bit l);
    logic [CH*IN_W-1:0] d;
    d[0*IN_W +: IN_W] = IN_W'(v0);
    d[1*IN_W +: IN_W] = IN_W'(v1);
    d[2*IN_W +: IN_W] = IN_W'(v2);
    d[3*IN_W +: IN_W] = IN_W'(v3);
    drive_beat(d, s, l);
  endtask

  task automatic drain();
    int waitc = 0;
    rdy_mode = 1;
    while (exp_q.size() != 0 || out_valid) begin
      @(negedge clk);
      waitc++;
      if (waitc > 200) begin
        checks++; errors++;
        $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
        finish_now();
      end
    end
    @(posedge clk); #2;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b0;
    tb_open = 1'b0;
    exp_q.delete();
    model_clear();
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: out_ready = ($urandom_range(0, 3) != 0);
      1: out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard on every consumed result plus stall/handshake/busy checks.
  logic [CH*ACC_W-1:0] held;
  bit stall_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_data_stable", out_data, held);
      chk("wrap_valid_match", out_valid_w, out_valid);
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      chk("busy", {busy_w, busy}, {tb_open, tb_open});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %h required none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data_sat", out_data, e.ds);
          chk("data_wrap", out_data_w, e.dw);
          chk("ovf_sat", out_ovf, e.os);
          chk("ovf_wrap", out_ovf_w, e.ow);
          chk("count", {out_count_w, out_count}, {e.cnt, e.cnt});
        end
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
    end
  end

  initial begin
    model_clear();
    @(posedge clk); #2;
    do_reset(3);
    @(negedge clk);
    chk("reset_out_valid", {out_valid_w, out_valid}, 2'b00);
    chk("reset_busy", {busy_w, busy}, 2'b00);
    chk("reset_out_data", out_data, '0);
    chk("reset_out_count", out_count, '0);
    chk("reset_out_ovf", out_ovf, '0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #2;

    // Basic signed accumulation, then a group that must start from zero.
    beat4(5, 0, 0, 0, 1, 0);
    beat4(-3, 0, 0, 0, 1, 0);
    beat4(10, 0, 0, 0, 1, 1);
    beat4(1, 0, 0, 0, 1, 1);
    drain();

    // Extension modes.
    beat4(0, 20'hFFFFF, 0, 0, 0, 1);
    beat4(0, 20'hFFFFF, 0, 0, 1, 1);
    drain();

    // Saturation / wrap with counter saturation.
    for (int i = 0; i < 300; i++) beat4(1, 0, 20'h7FFFF, -1, 1, (i == 299));
    drain();

    // Back-pressure: a stalled result blocks the next group.
    rdy_mode = 2;
    @(posedge clk); #2;
    beat4(3, 4, 5, 6, 1, 1);
    in_valid = 1'b1; in_data = '1; in_signed = 1'b1; in_last = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    rdy_mode = 1;
    beat4(-1, -1, -1, -1, 1, 0);
    // Back-to-back single-beat groups: completion and consume in the same cycle.
    for (int k = 0; k < 8; k++) begin
      if (k > 1) chk("b2b_valid", out_valid, 1'b1);
      beat4(k, -k, 2*k, 100, 1, 1);
    end
    drain();

    // Reset mid-group discards everything.
    beat4(9, 9, 9, 9, 1, 0);
    beat4(9, 9, 9, 9, 1, 0);
    do_reset(1);
    @(negedge clk);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_out_valid", out_valid, 1'b0);
    @(posedge clk); #2;
    beat4(7, 0, 0, 0, 1, 1);
    drain();

    // Mixed lanes, checks lane packing.
    beat4(-1, 2, -3, 4, 1, 0);
    beat4(-1, 2, -3, 4, 1, 1);
    drain();

    // Randomized groups with random back-pressure.
    rdy_mode = 0;
    for (int g = 0; g < 40; g++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        logic [CH*IN_W-1:0] d;
        for (int c = 0; c < CH; c++) d[c*IN_W +: IN_W] = IN_W'($urandom);
        drive_beat(d, 1'($urandom_range(0, 1)), (b == len - 1));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #2;
        end
      end
    end
    drain();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    finish_now();
  end

endmodule
`default_nettype wire

// File: doc/fusion_acc_array.md
Name: fusion_acc_array

Overview:
- Multi-channel, parametrised accumulator behind the fusion-unit adder trees.
- Accepts one signed or unsigned partial sum per channel per handshake beat and accumulates each channel independently.
- On a beat flagged last, it closes the group and presents per-channel totals through a one-entry output register with a valid/ready handshake.
- Optional saturation with sticky overflow flags. Also provides a beat counter per group.

Parameters:
- IN_W, 20, width of each channel's partial-sum input.
- ACC_W, 28, width of each channel accumulator and output; must be ≥ IN_W+1.
- CH, 4, number of independent channels.
- CNT_W, 8, width of the beat counter.
- SAT_EN, 1, 1 = saturate to signed ACC_W range; 0 = modulo-2^ACC_W wrap.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block can accept a beat.
- in_data, input, CH*IN_W, channel c occupies bits [c*IN_W +: IN_W].
- in_signed, input, 1, 1 = sign-extend in_data lanes; 0 = zero-extend. Sampled per beat.
- in_last, input, 1, beat closes the current group.
- out_valid, output, 1, result register holds an unconsumed group result.
- out_ready, input, 1, consumer accepts the result.
- out_data, output, CH*ACC_W, per-channel group totals, same lane packing as in_data.
- out_ovf, output, CH, per-channel sticky overflow/saturation flag for the group.
- out_count, output, CNT_W, number of beats in the group; saturates at 2^CNT_W-1.
- busy, output, 1, a group is open: at least one beat accepted, last not yet seen.

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset: acc[c] = 0, ovf[c] = 0, beat counter = 0, out_valid = 0, out_data = 0, out_ovf = 0, out_count = 0, busy = 0, state = IDLE.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - in_ready = !(out_valid && !out_ready), a combinational function of registered out_valid and out_ready.
  - Result consumed when out_valid && out_ready.
- Arithmetic per accepted beat, per channel:
  - ext = extend(in_data[c]) to ACC_W+1 bits, per in_signed.
  - sum = sext(acc[c]) + ext, computed in ACC_W+1 bits.
  - Overflow when sum is outside the signed ACC_W range.
  - SAT_EN = 1: result clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - SAT_EN = 0: result is the low ACC_W bits.
  - In both modes the channel's ovf is set on overflow and stays set until the group closes.
- States:
  - IDLE: no open group. An accepted non-last beat → RUN. An accepted last beat is a single-beat group, completes, and stays in IDLE.
  - RUN: group open, busy = 1. Accepted non-last beats stay in RUN. An accepted last beat → IDLE.
- Group completion, on an accepted last beat:
  - Next cycle: out_data = final sums including that beat; out_ovf = ovf | this beat's overflow; out_count = counter+1 (saturating).
  - out_valid = 1.
  - acc, ovf and counter are cleared to 0 in the same edge.
- Latency: result is visible 1 cycle after the last beat is accepted.
- Output register:
  - Holds its value while out_valid && !out_ready.
  - Cleared out_valid on consume unless a new completion occurs in the same cycle. In that case the new result is loaded and out_valid stays 1 (back-to-back).
  - Non-last beats are still blocked while the register is full and stalled, because in_ready = 0.
- Counter: increments per accepted beat; saturates at all-ones and never wraps.
- in_valid with in_ready = 0: no state change, and the input must be held by the source.
- Reset mid-group or with out_valid = 1: all state is discarded next edge and no result is produced.
- No accepted beat in a cycle: acc is unchanged.

Test Plan:
- Basic signed accumulation (CH=4, SAT_EN=1):
  - Stimulus: 3 beats, lane0 = 5, -3, 10 (last on 3rd).
  - Required: 1 cycle later, out_valid = 1, lane0 = 12, out_count = 3, out_ovf = 0.
  - Required: the next group starts from 0.
- Unsigned extension:
  - Stimulus: lane1 = 20'hFFFFF with in_signed = 0, single last beat.
  - Required: lane1 = 28'h00FFFFF.
  - Stimulus: same value with in_signed = 1.
  - Required: lane1 = 28'hFFFFFFF (−1).
- Saturation:
  - Stimulus: lane2 = 20'h7FFFF for 300 beats.
  - Required: lane2 = 28'h7FFFFFF, out_ovf[2] = 1, out_count = 255.
  - Required: other lanes unaffected.
  - Stimulus: repeat with SAT_EN = 0.
  - Required: wrapped value (300·524287) mod 2^28, with out_ovf[2] = 1.
- Back-pressure:
  - Stimulus: out_ready = 0 after a completion; drive the next group's beats.
  - Required: in_ready = 0 and out_data is stable.
  - Stimulus: out_ready = 1 in the same cycle a last beat is accepted.
  - Required: no bubble, the new result is loaded, and no group is lost.
- Reset mid-group:
  - Stimulus: 2 non-last beats, then assert reset for one cycle.
  - Required: busy = 0, out_valid = 0, and a following single last beat of 7 yields lane0 = 7, count = 1.
- Mixed lanes:
  - Stimulus: lanes = {-1, 2, -3, 4}, twice, last on the 2nd.
  - Required: out lanes = {-2, 4, -6, 8}, correctly packed.
